// File: rtl/instruction_fetch_pkg.sv
// Shared fetch/decode constants: opcodes, default widths, nop word and the fetch state type.
// Decode and execute import the same package so opcode values stay in one place.
package instruction_fetch_pkg;

  localparam logic [5:0]  OP_J       = 6'b000010;
  localparam logic [5:0]  OP_BGT     = 6'b000111;
  localparam logic [5:0]  OP_NOP     = 6'b000000;
  localparam int          ADDR_W_DEF = 7;
  localparam int          DATA_W_DEF = 32;
  localparam logic [31:0] NOP_WORD   = 32'h0000_0000;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_ifid_reg.sv
// IF/ID pipeline register: instruction, its PC and a valid bit, with hold and flush.
// Flush outranks hold so a redirect can squash a stalled slot.
module ifid_reg
  import instruction_fetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              flush,
  input  logic [DATA_W-1:0] load_instr,
  input  logic [ADDR_W-1:0] load_pc,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] pc,
  output logic              valid
);

  // A flushed slot becomes a nop bubble; its pc field is left as-is since nothing reads it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr <= '0;
      pc    <= '0;
      valid <= 1'b0;
    end else if (flush) begin
      instr <= '0;
      valid <= 1'b0;
    end else if (!hold) begin
      instr <= load_instr;
      pc    <= load_pc;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC register, next-PC mux (redirect / stall / local j / pc+1) and IF/ID register.
// Optional HALT_DETECT_EN: a fetched jump-to-self parks the stage in HALT until reset.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                DATA_W   = DATA_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_instr,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic              if_valid,
  output logic              halted
);

  localparam logic [ADDR_W-1:0] PC_ONE = 1;

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] jump_target;
  logic              is_jump;
  logic              hold;
  logic              flush;
  logic              in_halt;

  assign imem_addr   = pc;
  assign is_jump     = (imem_instr[DATA_W-1:DATA_W-6] == OP_J);
  assign jump_target = imem_instr[ADDR_W-1:0];

`ifdef HALT_DETECT_EN
  fetch_state_t state_q;
  fetch_state_t state_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  // Halt only on a jump that would actually be taken this edge (no redirect, no stall).
  always_comb begin
    state_d = state_q;
    if (state_q == RUN && !branch_taken && !stall && is_jump && jump_target == pc)
      state_d = HALT;
  end

  assign in_halt = (state_q == HALT);
`else
  assign in_halt = 1'b0;
`endif

  assign halted = in_halt;

  // Priority: halted park, redirect, stall, local jump, sequential.
  always_comb begin
    pc_next = pc;
    hold    = 1'b0;
    flush   = 1'b0;
    if (in_halt) begin
      flush = 1'b1;
    end else if (branch_taken) begin
      pc_next = branch_target;
      flush   = 1'b1;
    end else if (stall) begin
      hold = 1'b1;
    end else if (is_jump) begin
      pc_next = jump_target;
    end else begin
      pc_next = pc + PC_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc <= RESET_PC;
    else       pc <= pc_next;
  end

  ifid_reg #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_ifid (
    .clk        (clk),
    .reset      (reset),
    .hold       (hold),
    .flush      (flush),
    .load_instr (imem_instr),
    .load_pc    (pc),
    .instr      (if_instr),
    .pc         (if_pc),
    .valid      (if_valid)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a behavioural 128x32 ROM.
// Build with +define+HALT_DETECT_EN to exercise the halt variant.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [6:0]  branch_target;
  logic [6:0]  imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] if_instr;
  logic [6:0]  if_pc;
  logic        if_valid;
  logic        halted;

  logic [31:0] rom [128];
  int checks   = 0;
  int failures = 0;

  assign imem_instr = rom[imem_addr];

  always #5 clk = ~clk;

  instruction_fetch dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_addr     (imem_addr),
    .imem_instr    (imem_instr),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .if_valid      (if_valid),
    .halted        (halted)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stimulus only: one redirect edge, then branch_taken dropped.
  task automatic redirect(input logic [6:0] target);
    branch_taken  = 1'b1;
    branch_target = target;
    tick();
    branch_taken  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    repeat (3) tick();
    checks++; if (imem_addr !== 7'd0) begin failures++; $display("FAIL reset_pc got=%0d exp=0", imem_addr); end
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", if_valid); end
    checks++; if (if_instr !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h exp=0", if_instr); end
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%b exp=0", halted); end
    reset = 1'b0;
    tick();
    checks++; if (if_pc !== 7'd0 || if_valid !== 1'b1) begin failures++; $display("FAIL first_fetch if_pc=%0d valid=%b exp 0/1", if_pc, if_valid); end
    checks++; if (imem_addr !== 7'd1) begin failures++; $display("FAIL first_pc got=%0d exp=1", imem_addr); end
  endtask

  task automatic test_straight_line();
    logic [31:0] exp_word [4];
    exp_word[0] = 32'h2001_0005; exp_word[1] = 32'h8C02_0000;
    exp_word[2] = 32'h8C03_0004; exp_word[3] = 32'h0043_2022;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (if_pc !== 7'(i + 1) || if_instr !== exp_word[i] || if_valid !== 1'b1) begin
        failures++;
        $display("FAIL straight_%0d if_pc=%0d instr=%h valid=%b exp pc=%0d instr=%h valid=1",
                 i + 1, if_pc, if_instr, if_valid, i + 1, exp_word[i]);
      end
    end
  endtask

  task automatic test_stall();
    tick();
    checks++; if (if_pc !== 7'd5 || imem_addr !== 7'd6) begin failures++; $display("FAIL pre_stall if_pc=%0d pc=%0d exp 5/6", if_pc, imem_addr); end
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (imem_addr !== 7'd6 || if_pc !== 7'd5 || if_instr !== 32'h2000_0005 || if_valid !== 1'b1) begin
        failures++;
        $display("FAIL stall_hold_%0d pc=%0d if_pc=%0d instr=%h valid=%b exp 6/5/20000005/1",
                 i, imem_addr, if_pc, if_instr, if_valid);
      end
    end
    stall = 1'b0;
    tick();
    checks++; if (if_pc !== 7'd6 || if_instr !== 32'h2000_0006) begin failures++; $display("FAIL stall_resume if_pc=%0d instr=%h exp 6/20000006", if_pc, if_instr); end
  endtask

  task automatic test_jump();
    redirect(7'd12);
    checks++; if (imem_addr !== 7'd12 || if_valid !== 1'b0 || if_instr !== 32'h0) begin failures++; $display("FAIL redirect12 pc=%0d valid=%b instr=%h exp 12/0/0", imem_addr, if_valid, if_instr); end
    tick();
    checks++; if (if_pc !== 7'd12 || if_instr !== 32'h0800_0093 || if_valid !== 1'b1) begin failures++; $display("FAIL jump_latched if_pc=%0d instr=%h valid=%b exp 12/08000093/1", if_pc, if_instr, if_valid); end
    checks++; if (imem_addr !== 7'd19) begin failures++; $display("FAIL jump_target got=%0d exp=19", imem_addr); end
    tick();
    checks++; if (if_pc !== 7'd19 || if_valid !== 1'b1 || if_instr !== 32'h2000_0013) begin failures++; $display("FAIL jump_no_bubble if_pc=%0d valid=%b instr=%h exp 19/1/20000013", if_pc, if_valid, if_instr); end
  endtask

  task automatic test_branch_over_stall();
    stall = 1'b1;
    redirect(7'd13);
    checks++; if (imem_addr !== 7'd13 || if_valid !== 1'b0 || if_instr !== 32'h0) begin failures++; $display("FAIL branch_wins pc=%0d valid=%b instr=%h exp 13/0/0", imem_addr, if_valid, if_instr); end
    stall = 1'b0;
    tick();
    checks++; if (if_pc !== 7'd13 || if_valid !== 1'b1 || if_instr !== 32'h2000_000D) begin failures++; $display("FAIL branch_refetch if_pc=%0d valid=%b instr=%h exp 13/1/2000000d", if_pc, if_valid, if_instr); end
  endtask

  task automatic test_wrap();
    redirect(7'd127);
    tick();
    checks++; if (if_pc !== 7'd127 || imem_addr !== 7'd0) begin failures++; $display("FAIL wrap_edge if_pc=%0d pc=%0d exp 127/0", if_pc, imem_addr); end
    tick();
    checks++; if (if_pc !== 7'd0 || if_instr !== 32'h0 || if_valid !== 1'b1) begin failures++; $display("FAIL wrap_fetch if_pc=%0d instr=%h valid=%b exp 0/0/1", if_pc, if_instr, if_valid); end
  endtask

  task automatic test_jump_to_self();
    redirect(7'd38);
    tick();
    checks++; if (if_pc !== 7'd38 || if_instr !== 32'h0800_0026 || if_valid !== 1'b1 || imem_addr !== 7'd38) begin failures++; $display("FAIL self_fetch if_pc=%0d instr=%h valid=%b pc=%0d exp 38/08000026/1/38", if_pc, if_instr, if_valid, imem_addr); end
`ifdef HALT_DETECT_EN
    checks++; if (halted !== 1'b1) begin failures++; $display("FAIL halt_set got=%b exp=1", halted); end
    tick();
    checks++; if (if_valid !== 1'b0 || imem_addr !== 7'd38 || halted !== 1'b1) begin failures++; $display("FAIL halt_park valid=%b pc=%0d halted=%b exp 0/38/1", if_valid, imem_addr, halted); end
    redirect(7'd5);
    checks++; if (imem_addr !== 7'd38 || halted !== 1'b1) begin failures++; $display("FAIL halt_sticky pc=%0d halted=%b exp 38/1", imem_addr, halted); end
`else
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL halt_tied got=%b exp=0", halted); end
    tick();
    checks++; if (if_pc !== 7'd38 || if_valid !== 1'b1 || imem_addr !== 7'd38) begin failures++; $display("FAIL self_loop if_pc=%0d valid=%b pc=%0d exp 38/1/38", if_pc, if_valid, imem_addr); end
`endif
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (imem_addr !== 7'd0 || if_valid !== 1'b0 || if_instr !== 32'h0 || halted !== 1'b0) begin failures++; $display("FAIL async_reset pc=%0d valid=%b instr=%h halted=%b exp 0/0/0/0", imem_addr, if_valid, if_instr, halted); end
    tick();
    reset = 1'b0;
    tick();
    checks++; if (if_pc !== 7'd0 || if_valid !== 1'b1) begin failures++; $display("FAIL post_reset if_pc=%0d valid=%b exp 0/1", if_pc, if_valid); end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) rom[i] = 32'h2000_0000 + 32'(i);
    rom[0]  = 32'h0000_0000;
    rom[1]  = 32'h2001_0005;
    rom[2]  = 32'h8C02_0000;
    rom[3]  = 32'h8C03_0004;
    rom[4]  = 32'h0043_2022;
    rom[12] = 32'h0800_0093;
    rom[38] = 32'h0800_0026;

    test_reset();
    test_straight_line();
    test_stall();
    test_jump();
    test_branch_over_stall();
    test_wrap();
    test_jump_to_self();
    test_async_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
